// File: rtl/toggle_load_gen_pkg.sv
// -----------------------------------------------------------------------------
// toggle_load_gen_pkg
//
// Purpose : shared definitions for the switching-load generator. It holds the
//           per-channel pattern-source modes, the LFSR seed and tap mask, and
//           the LFSR step function. The top and the channel chain both use it.
//
// Contents:
//   mode_e     2-bit pattern-source selector (static, toggle, LFSR, burst)
//   LfsrSeed   value the shared LFSR is loaded with on reset
//   LfsrTaps   Galois feedback mask, applied when the bit shifted out is 1
//   lfsr_next  one right-shifting Galois step
// -----------------------------------------------------------------------------
package toggle_load_gen_pkg;

    typedef enum logic [1:0] {
        ModeStatic = 2'd0,
        ModeToggle = 2'd1,
        ModeLfsr   = 2'd2,
        ModeBurst  = 2'd3
    } mode_e;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    // Right-shifting Galois form: bit 0 leaves, taps fold back when it was 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/toggle_load_gen_chain.sv
// -----------------------------------------------------------------------------
// toggle_load_gen_chain
//
// Purpose : one load channel. A mode-selected inject flop feeds a long shift
//           chain, and every flop in the chain switches when the pattern does.
//           The chain tail drives a divided probe output and a toggle counter.
//
// Ports:
//   main_clk      in   1        single clock, posedge
//   reset         in   1        asynchronous, active-high
//   run_s         in   1        synchronised run; 0 freezes the inject bit
//   mode          in   mode_e   pattern source for this channel
//   lfsr_bit      in   1        bit 0 of the shared LFSR
//   burst_active  in   1        shared burst on-window flag
//   tail          out  1        last chain flop
//   div_out       out  1        toggles every 2**(DIV_LOG2-1) tail rises
//   tog_cnt       out  CNTR_W   count of tail toggles, wraps
// -----------------------------------------------------------------------------
module toggle_load_gen_chain
    import toggle_load_gen_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 750,
    parameter int unsigned DIV_LOG2  = 5,
    parameter int unsigned CNTR_W    = 22
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              run_s,
    input  mode_e             mode,
    input  logic              lfsr_bit,
    input  logic              burst_active,
    output logic              tail,
    output logic              div_out,
    output logic [CNTR_W-1:0] tog_cnt
);

    localparam int unsigned DivW = DIV_LOG2 - 1;

    logic inj_q, inj_d;

    // The chain is the load itself. It must stay as discrete flops, so
    // synthesis must not merge it or map it onto shift-register or RAM
    // primitives.
    (* keep = "true", preserve = "true" *) logic [CHAIN_LEN-1:0] chain_q;

    logic              tail_prev_q;
    logic [DivW-1:0]   div_cnt_q;
    logic              div_out_q;
    logic [CNTR_W-1:0] tog_cnt_q;

    logic tail_edge;
    logic tail_rise;

    assign tail      = chain_q[CHAIN_LEN-1];
    assign tail_edge = tail ^ tail_prev_q;
    assign tail_rise = tail & ~tail_prev_q;
    assign div_out   = div_out_q;
    assign tog_cnt   = tog_cnt_q;

    always_comb begin
        inj_d = inj_q;
        if (run_s) begin
            unique case (mode)
                ModeStatic: inj_d = 1'b0;
                ModeToggle: inj_d = ~inj_q;
                ModeLfsr:   inj_d = lfsr_bit;
                ModeBurst:  inj_d = burst_active ? ~inj_q : inj_q;
            endcase
        end
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            inj_q       <= 1'b0;
            chain_q     <= '0;
            tail_prev_q <= 1'b0;
            div_cnt_q   <= '0;
            div_out_q   <= 1'b0;
            tog_cnt_q   <= '0;
        end else begin
            inj_q       <= inj_d;
            // Shifts every cycle whatever run is, so stale contents drain by themselves.
            chain_q     <= {chain_q[CHAIN_LEN-2:0], inj_q};
            tail_prev_q <= tail;
            if (tail_rise) begin
                div_cnt_q <= div_cnt_q + DivW'(1);
                if (&div_cnt_q) begin
                    div_out_q <= ~div_out_q;
                end
            end
            if (tail_edge) begin
                tog_cnt_q <= tog_cnt_q + CNTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/toggle_load_gen.sv
// -----------------------------------------------------------------------------
// toggle_load_gen
//
// Purpose : multi-channel switching-load generator for side-channel work.
//           Each channel shifts a pattern (static, toggle, LFSR or gated
//           burst) through a long flop chain. Each chain tail drives a
//           probe-pin divider and a toggle counter. This block holds the run
//           synchroniser, the shared LFSR and the shared burst framer.
//
// Ports:
//   main_clk      in   1             single clock, all logic on posedge
//   reset         in   1             asynchronous, active-high
//   run           in   1             asynchronous button, synchronised here
//   ch_mode       in   2*NR_CH       channel i mode at [2i+1:2i]
//   burst_period  in   BURST_W       burst frame length, 0 acts as 1
//   burst_on      in   BURST_W       on-cycles per frame, >= period means always on
//   tail          out  NR_CH         registered chain tail per channel
//   div_out       out  NR_CH         divided tail indicator per channel
//   tog_cnt       out  CNTR_W*NR_CH  channel i toggle count at [i*CNTR_W +: CNTR_W]
//   burst_active  out  1             high during the on-window of the frame
// -----------------------------------------------------------------------------
module toggle_load_gen
    import toggle_load_gen_pkg::*;
#(
    parameter int unsigned NR_CH     = 4,
    parameter int unsigned CHAIN_LEN = 750,
    parameter int unsigned DIV_LOG2  = 5,
    parameter int unsigned CNTR_W    = 22,
    parameter int unsigned BURST_W   = 16
) (
    input  logic                    main_clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [2*NR_CH-1:0]      ch_mode,
    input  logic [BURST_W-1:0]      burst_period,
    input  logic [BURST_W-1:0]      burst_on,
    output logic [NR_CH-1:0]        tail,
    output logic [NR_CH-1:0]        div_out,
    output logic [CNTR_W*NR_CH-1:0] tog_cnt,
    output logic                    burst_active
);

    logic               run_meta_q;
    logic               run_s_q;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0] burst_len;
    logic               burst_active_q, burst_active_d;

    assign burst_active = burst_active_q;

    always_comb begin
        burst_len = (burst_period == '0) ? BURST_W'(1) : burst_period;
        // A compare with >= rather than == also wraps at once when the period
        // shrinks below the current count.
        if (burst_cnt_q >= burst_len - BURST_W'(1)) begin
            burst_cnt_d = '0;
        end else begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
        burst_active_d = (burst_cnt_q < burst_on);
        lfsr_d         = run_s_q ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            run_meta_q     <= 1'b0;
            run_s_q        <= 1'b0;
            lfsr_q         <= LfsrSeed;
            burst_cnt_q    <= '0;
            burst_active_q <= 1'b0;
        end else begin
            run_meta_q     <= run;
            run_s_q        <= run_meta_q;
            lfsr_q         <= lfsr_d;
            burst_cnt_q    <= burst_cnt_d;
            burst_active_q <= burst_active_d;
        end
    end

    for (genvar i = 0; i < NR_CH; i++) begin : g_ch
        toggle_load_gen_chain #(
            .CHAIN_LEN (CHAIN_LEN),
            .DIV_LOG2  (DIV_LOG2),
            .CNTR_W    (CNTR_W)
        ) u_chain (
            .main_clk     (main_clk),
            .reset        (reset),
            .run_s        (run_s_q),
            .mode         (mode_e'(ch_mode[2*i +: 2])),
            .lfsr_bit     (lfsr_q[0]),
            .burst_active (burst_active_q),
            .tail         (tail[i]),
            .div_out      (div_out[i]),
            .tog_cnt      (tog_cnt[i*CNTR_W +: CNTR_W])
        );
    end

endmodule

// File: tb/tb_toggle_load_gen.sv
// -----------------------------------------------------------------------------
// tb_toggle_load_gen
//
// Bench for toggle_load_gen with 2 channels, 8-flop chains, a divide-by-4-rises
// divider and 4-bit toggle counters. Cycle n means the state after the n-th
// posedge that follows reset release. Inputs change and outputs are sampled on
// the negedge.
// -----------------------------------------------------------------------------
module tb_toggle_load_gen;

    localparam int unsigned NrCh     = 2;
    localparam int unsigned ChainLen = 8;
    localparam int unsigned DivLog2  = 3;
    localparam int unsigned CntrW    = 4;
    localparam int unsigned BurstW   = 16;

    logic                    main_clk = 1'b0;
    logic                    reset;
    logic                    run;
    logic [2*NrCh-1:0]       ch_mode;
    logic [BurstW-1:0]       burst_period;
    logic [BurstW-1:0]       burst_on;
    logic [NrCh-1:0]         tail;
    logic [NrCh-1:0]         div_out;
    logic [CntrW*NrCh-1:0]   tog_cnt;
    logic                    burst_active;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 main_clk = ~main_clk;

    toggle_load_gen #(
        .NR_CH     (NrCh),
        .CHAIN_LEN (ChainLen),
        .DIV_LOG2  (DivLog2),
        .CNTR_W    (CntrW),
        .BURST_W   (BurstW)
    ) dut (
        .main_clk     (main_clk),
        .reset        (reset),
        .run          (run),
        .ch_mode      (ch_mode),
        .burst_period (burst_period),
        .burst_on     (burst_on),
        .tail         (tail),
        .div_out      (div_out),
        .tog_cnt      (tog_cnt),
        .burst_active (burst_active)
    );

    typedef struct {
        logic        run;
        logic [1:0]  m0;
        logic [1:0]  m1;
        logic [15:0] per;
        logic [15:0] on;
        int unsigned cyc;
        logic [1:0]  tail;
        logic [1:0]  div;
        logic [3:0]  tog0;
        logic [3:0]  tog1;
        logic        ba;
    } vec_t;

    localparam int NVec = 19;
    vec_t vecs[NVec];

    function automatic vec_t mk(input logic r, input logic [1:0] m0, input logic [1:0] m1,
                                input logic [15:0] per, input logic [15:0] on,
                                input int unsigned cyc, input logic [1:0] t,
                                input logic [1:0] d, input logic [3:0] c0,
                                input logic [3:0] c1, input logic ba);
        vec_t v;
        v.run = r; v.m0 = m0; v.m1 = m1; v.per = per; v.on = on; v.cyc = cyc;
        v.tail = t; v.div = d; v.tog0 = c0; v.tog1 = c1; v.ba = ba;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Reassert reset with new inputs, then release it on a negedge.
    task automatic start(input logic r, input logic [1:0] m0, input logic [1:0] m1,
                         input logic [15:0] per, input logic [15:0] on);
        @(negedge main_clk);
        reset        = 1'b1;
        run          = r;
        ch_mode      = {m1, m0};
        burst_period = per;
        burst_on     = on;
        repeat (2) @(negedge main_clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] lf;
        logic        exp_bit;
        logic [5:0]  ba_exp;

        reset        = 1'b1;
        run          = 1'b1;
        ch_mode      = 4'b0001;
        burst_period = 16'd1;
        burst_on     = 16'd1;

        // run, m0, m1, per, on, cycle, tail{1,0}, div{1,0}, tog0, tog1, burst_active
        // ch0 toggle: tail(n)=(n-10)&1, tog0(n)=n-11 mod 16, div0 flips at 18, 26, ...
        vecs[0]  = mk(1, 1, 0, 1, 1, 10,  2'b00, 2'b00, 0,  0, 1);
        vecs[1]  = mk(1, 1, 0, 1, 1, 11,  2'b01, 2'b00, 0,  0, 1);
        vecs[2]  = mk(1, 1, 0, 1, 1, 12,  2'b00, 2'b00, 1,  0, 1);
        vecs[3]  = mk(1, 1, 0, 1, 1, 17,  2'b01, 2'b00, 6,  0, 1);
        vecs[4]  = mk(1, 1, 0, 1, 1, 18,  2'b00, 2'b01, 7,  0, 1);
        vecs[5]  = mk(1, 1, 0, 1, 1, 26,  2'b00, 2'b00, 15, 0, 1);
        vecs[6]  = mk(1, 1, 0, 1, 1, 27,  2'b01, 2'b00, 0,  0, 1);
        vecs[7]  = mk(1, 1, 0, 1, 1, 100, 2'b00, 2'b01, 9,  0, 1);
        // The same pattern on ch1, with ch0 static.
        vecs[8]  = mk(1, 0, 1, 1, 1, 18,  2'b00, 2'b10, 0,  7, 1);
        // Run low: the inject bits hold 0.
        vecs[9]  = mk(0, 1, 1, 1, 1, 30,  2'b00, 2'b00, 0,  0, 1);
        // ch0 burst with period 10, on 3. Tail edges occur at 11,12,20,21,22,30,31,32.
        vecs[10] = mk(1, 3, 0, 10, 3, 12, 2'b00, 2'b00, 1,  0, 1);
        vecs[11] = mk(1, 3, 0, 10, 3, 20, 2'b01, 2'b00, 2,  0, 0);
        vecs[12] = mk(1, 3, 0, 10, 3, 23, 2'b01, 2'b00, 5,  0, 1);
        vecs[13] = mk(1, 3, 0, 10, 3, 31, 2'b01, 2'b00, 6,  0, 1);
        vecs[14] = mk(1, 3, 0, 10, 3, 32, 2'b00, 2'b01, 7,  0, 1);
        vecs[15] = mk(1, 3, 0, 10, 3, 34, 2'b00, 2'b01, 8,  0, 0);
        // Burst boundaries: period 0 acts as 1, and on >= period keeps it always on.
        vecs[16] = mk(1, 0, 0, 0, 1, 5,   2'b00, 2'b00, 0,  0, 1);
        vecs[17] = mk(1, 0, 0, 0, 0, 5,   2'b00, 2'b00, 0,  0, 0);
        vecs[18] = mk(1, 0, 0, 3, 5, 7,   2'b00, 2'b00, 0,  0, 1);

        // Everything stays clear while reset is held, even with run=1 and toggle mode.
        for (int i = 0; i < 5; i++) begin
            @(negedge main_clk);
            chk("reset_hold", i, {24'd0, tail, div_out, tog_cnt} | {31'd0, burst_active}, 0);
        end

        for (int v = 0; v < NVec; v++) begin
            start(vecs[v].run, vecs[v].m0, vecs[v].m1, vecs[v].per, vecs[v].on);
            repeat (vecs[v].cyc) @(negedge main_clk);
            chk("vec_tail", v, {30'd0, tail}, {30'd0, vecs[v].tail});
            chk("vec_div", v, {30'd0, div_out}, {30'd0, vecs[v].div});
            chk("vec_tog0", v, {28'd0, tog_cnt[CntrW-1:0]}, {28'd0, vecs[v].tog0});
            chk("vec_tog1", v, {28'd0, tog_cnt[2*CntrW-1:CntrW]}, {28'd0, vecs[v].tog1});
            chk("vec_burst", v, {31'd0, burst_active}, {31'd0, vecs[v].ba});
        end

        // LFSR mode on both channels: tail(n) = step^(n-11)(ACE1)[0] from cycle 11.
        start(1, 2, 2, 1, 1);
        lf = 16'hACE1;
        for (int n = 1; n <= 42; n++) begin
            @(negedge main_clk);
            if (n <= 10) begin
                exp_bit = 1'b0;
            end else begin
                exp_bit = lf[0];
                lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
            end
            chk("lfsr_tail0", n, {31'd0, tail[0]}, {31'd0, exp_bit});
            chk("lfsr_tail1", n, {31'd0, tail[1]}, {31'd0, exp_bit});
        end

        // Shrinking the period below the live count (7) wraps the counter next cycle.
        start(1, 0, 0, 10, 3);
        repeat (7) @(negedge main_clk);
        chk("per_shrink", 7, {31'd0, burst_active}, 0);
        burst_period = 16'd4;
        ba_exp = 6'b101110;  // bit k is the expected value at cycle 8+k
        for (int k = 0; k < 6; k++) begin
            @(negedge main_clk);
            chk("per_shrink", 8 + k, {31'd0, burst_active}, {31'd0, ba_exp[k]});
        end

        // Mode change mid-run: ch0 goes static after cycle 20, and the last tail edge is at 28.
        start(1, 1, 0, 1, 1);
        repeat (20) @(negedge main_clk);
        ch_mode = 4'b0000;
        repeat (20) @(negedge main_clk);
        chk("mode_chg_tail", 40, {31'd0, tail[0]}, 0);
        chk("mode_chg_tog", 40, {28'd0, tog_cnt[CntrW-1:0]}, 2);

        // Reset in the middle of a burst clears everything without waiting for a clock edge.
        start(1, 3, 1, 10, 3);
        repeat (23) @(negedge main_clk);
        chk("pre_rst_tail", 23, {30'd0, tail}, 3);
        chk("pre_rst_tog", 23, {24'd0, tog_cnt}, {24'd0, 4'd12, 4'd5});
        chk("pre_rst_burst", 23, {31'd0, burst_active}, 1);
        reset = 1'b1;
        #1;
        chk("async_rst", 0, {24'd0, tail, div_out, tog_cnt} | {31'd0, burst_active}, 0);
        run     = 1'b0;
        ch_mode = 4'b0000;
        @(negedge main_clk);
        reset = 1'b0;
        // The chains held 1s before reset, so any survivor would reach the tail here.
        for (int n = 1; n <= 12; n++) begin
            @(negedge main_clk);
            chk("post_rst_tail", n, {30'd0, tail}, 0);
        end
        chk("post_rst_tog", 12, {24'd0, tog_cnt}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
